// File: rtl/calc_key_sequencer.sv
`default_nettype none
// ============================================================================
// calc_key_sequencer : keypad-driven add/sub calculator streaming its decimal
//                      result as ASCII to a UART transmitter.
// Revision 1.0
// ============================================================================
module calc_key_sequencer #(
  parameter int DIGITS = 4,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic [W-1:0] disp_val,
  output logic         ovf
);

  localparam int PW = $clog2(DIGITS + 1);
  localparam int BW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(W);
  localparam logic [PW-1:0] MAX_CNT  = PW'(DIGITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [2:0] {S_A, S_B, S_CALC, S_CONV, S_SEND} state_t;
  typedef enum logic [1:0] {P_SIGN, P_DIG, P_CR, P_LF} phase_t;

  state_t          state_q;
  phase_t          ph_q;
  logic [W-1:0]    a_q, b_q, mag_q, disp_q;
  logic [PW-1:0]   cnt_a_q, cnt_b_q, rem_q;
  logic [CW-1:0]   bit_q;
  logic [BW-1:0]   bcd_q;
  logic [7:0]      tx_data_q;
  logic            op_sub_q, neg_q, tx_valid_q, busy_q, ovf_q;

  logic            key_acc_d, is_digit_d;
  logic [W-1:0]    opnd_d, acc_d;
  logic [BW-1:0]   bcd_adj_d, bcd_d, align_d;
  logic [PW-1:0]   lead_d, shamt_d;

  always_comb begin
    key_acc_d  = key_valid && !busy_q;
    is_digit_d = (key_code <= 4'd9);
    opnd_d     = (state_q == S_B) ? b_q : a_q;
    acc_d      = opnd_d * W'(10) + W'(key_code);

    // One double-dabble step: add 3 to every digit >= 5, then shift in next bit.
    bcd_adj_d = bcd_q;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = BW'({bcd_adj_d, mag_q[W-1]});

    lead_d = '0;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd_d[4*i +: 4] != 4'd0) lead_d = PW'(i);
    end
    // Left-align the most significant non-zero digit so sending reads the top nibble.
    shamt_d = MAX_CNT - lead_d;
    align_d = bcd_d << (4 * shamt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_A;
      ph_q       <= P_SIGN;
      a_q        <= '0;
      b_q        <= '0;
      mag_q      <= '0;
      disp_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      rem_q      <= '0;
      bit_q      <= '0;
      bcd_q      <= '0;
      tx_data_q  <= '0;
      op_sub_q   <= 1'b0;
      neg_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_A, S_B: begin
          if (key_acc_d) begin
            if (is_digit_d) begin
              if (state_q == S_A) begin
                if (cnt_a_q < MAX_CNT) begin
                  a_q     <= acc_d;
                  disp_q  <= acc_d;
                  cnt_a_q <= cnt_a_q + 1'b1;
                end else begin
                  ovf_q <= 1'b1;
                end
              end else begin
                if (cnt_b_q < MAX_CNT) begin
                  b_q     <= acc_d;
                  disp_q  <= acc_d;
                  cnt_b_q <= cnt_b_q + 1'b1;
                end else begin
                  ovf_q <= 1'b1;
                end
              end
            end else begin
              case (key_code)
                4'd10, 4'd11: begin
                  if (state_q == S_A) begin
                    op_sub_q <= key_code[0];
                    b_q      <= '0;
                    cnt_b_q  <= '0;
                    disp_q   <= '0;
                    state_q  <= S_B;
                  end else if (cnt_b_q == '0) begin
                    op_sub_q <= key_code[0];
                  end
                end
                4'd12: begin
                  a_q      <= '0;
                  b_q      <= '0;
                  cnt_a_q  <= '0;
                  cnt_b_q  <= '0;
                  op_sub_q <= 1'b0;
                  ovf_q    <= 1'b0;
                  disp_q   <= '0;
                  state_q  <= S_A;
                end
                4'd13: begin
                  if (state_q == S_A) begin
                    b_q      <= '0;
                    op_sub_q <= 1'b0;
                  end
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
                end
                default: ;
              endcase
            end
          end
        end

        S_CALC: begin
          if (op_sub_q && (a_q < b_q)) begin
            neg_q <= 1'b1;
            mag_q <= b_q - a_q;
          end else begin
            neg_q <= 1'b0;
            mag_q <= op_sub_q ? (a_q - b_q) : (a_q + b_q);
          end
          bcd_q   <= '0;
          bit_q   <= '0;
          state_q <= S_CONV;
        end

        S_CONV: begin
          bcd_q <= bcd_d;
          mag_q <= mag_q << 1;
          bit_q <= bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            bcd_q      <= align_d;
            rem_q      <= lead_d;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
            if (neg_q) begin
              tx_data_q <= 8'h2D;
              ph_q      <= P_SIGN;
            end else begin
              tx_data_q <= {4'h3, align_d[BW-1 -: 4]};
              ph_q      <= P_DIG;
            end
          end
        end

        S_SEND: begin
          if (tx_ready) begin
            case (ph_q)
              P_SIGN: begin
                tx_data_q <= {4'h3, bcd_q[BW-1 -: 4]};
                ph_q      <= P_DIG;
              end
              P_DIG: begin
                if (rem_q == '0) begin
                  tx_data_q <= 8'h0D;
                  ph_q      <= P_CR;
                end else begin
                  bcd_q     <= bcd_q << 4;
                  tx_data_q <= {4'h3, bcd_q[BW-5 -: 4]};
                  rem_q     <= rem_q - 1'b1;
                end
              end
              P_CR: begin
                tx_data_q <= 8'h0A;
                ph_q      <= P_LF;
              end
              default: begin
                tx_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                a_q        <= '0;
                b_q        <= '0;
                cnt_a_q    <= '0;
                cnt_b_q    <= '0;
                op_sub_q   <= 1'b0;
                ovf_q      <= 1'b0;
                disp_q     <= '0;
                state_q    <= S_A;
              end
            endcase
          end
        end

        default: state_q <= S_A;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign disp_val = disp_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_sequencer.sv
`default_nettype none
// ============================================================================
// tb_calc_key_sequencer : scoreboard bench for the calculator key sequencer.
// Revision 1.0
// ============================================================================
module tb_calc_key_sequencer;

  localparam int DIGITS = 4;
  localparam int W      = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic [W-1:0] disp_val;
  logic         ovf;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sb[$];
  int          n_acc = 0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;
  logic        stall_seen = 1'b0;
  logic [7:0]  held = 8'h00;
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  calc_key_sequencer #(.DIGITS(DIGITS), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .disp_val (disp_val),
    .ovf      (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected byte; stalled bytes must hold.
  always @(negedge clk) begin
    if (!rst && stall_seen) begin
      check("stall_valid", {31'd0, tx_valid}, 32'd1);
      check("stall_data", {24'd0, tx_data}, {24'd0, held});
    end
    if (!rst && tx_valid && tx_ready) begin
      n_acc++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
      end else begin
        mon_exp = sb.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, mon_exp});
      end
    end
    stall_seen = !rst && tx_valid && !tx_ready;
    held       = tx_data;
  end

  // Ready driver: mode 0 always ready, mode 1 stalls each byte for 5 cycles.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      tx_ready = 1'b1;
    end else if (tx_valid && !tx_ready) begin
      stall_cnt++;
      if (stall_cnt >= 5) tx_ready = 1'b1;
    end else begin
      tx_ready  = 1'b0;
      stall_cnt = 0;
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    sb.push_back(b);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d required idle", name, busy, sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_disp", {16'd0, disp_val}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;

    // 12 + 7 = 19
    press(4'd1);  check("t1_disp_a1", {16'd0, disp_val}, 32'd1);
    press(4'd2);  check("t1_disp_a12", {16'd0, disp_val}, 32'd12);
    press(4'd10); check("t1_disp_b0", {16'd0, disp_val}, 32'd0);
    press(4'd7);  check("t1_disp_b7", {16'd0, disp_val}, 32'd7);
    check("t1_busy_before_eq", {31'd0, busy}, 32'd0);
    push(8'h31); push(8'h39); push(8'h0D); push(8'h0A);
    press(4'd13);
    check("t1_busy_after_eq", {31'd0, busy}, 32'd1);
    wait_done("t1");
    check("t1_end_disp", {16'd0, disp_val}, 32'd0);
    check("t1_end_valid", {31'd0, tx_valid}, 32'd0);

    // 5 - 23 = -18
    push(8'h2D); push(8'h31); push(8'h38); push(8'h0D); push(8'h0A);
    press(4'd5); press(4'd11); press(4'd2); press(4'd3);
    check("t2_disp_b23", {16'd0, disp_val}, 32'd23);
    press(4'd13);
    wait_done("t2");

    // digit overflow and clear
    for (int k = 1; k <= 6; k++) press(4'(k));
    check("t3_disp_1234", {16'd0, disp_val}, 32'd1234);
    check("t3_ovf_set", {31'd0, ovf}, 32'd1);
    press(4'd12);
    check("t3_clr_disp", {16'd0, disp_val}, 32'd0);
    check("t3_clr_ovf", {31'd0, ovf}, 32'd0);

    // zero result
    push(8'h30); push(8'h0D); push(8'h0A);
    press(4'd0); press(4'd13);
    wait_done("t4a");

    // 9999 + 9999 = 19998
    push(8'h31); push(8'h39); push(8'h39); push(8'h39); push(8'h38);
    push(8'h0D); push(8'h0A);
    for (int k = 0; k < 4; k++) press(4'd9);
    press(4'd10);
    for (int k = 0; k < 4; k++) press(4'd9);
    check("t4b_disp_9999", {16'd0, disp_val}, 32'd9999);
    press(4'd13);
    wait_done("t4b");

    // 45 - 6 = 39 with stalled transmitter and keys injected while busy
    rdy_mode = 1;
    push(8'h33); push(8'h39); push(8'h0D); push(8'h0A);
    press(4'd4); press(4'd5); press(4'd11); press(4'd6);
    check("t5_disp_b6", {16'd0, disp_val}, 32'd6);
    press(4'd13);
    repeat (20) @(posedge clk);
    press(4'd4);
    check("t5_busy_disp", {16'd0, disp_val}, 32'd6);
    press(4'd12);
    press(4'd13);
    check("t5_busy_hold", {31'd0, busy}, 32'd1);
    check("t5_busy_ovf", {31'd0, ovf}, 32'd0);
    wait_done("t5");
    rdy_mode = 0;
    repeat (30) @(posedge clk);
    press(4'd8);
    check("t5_next_operand", {16'd0, disp_val}, 32'd8);
    press(4'd12);

    // reset in the middle of "-18"
    push(8'h2D); push(8'h31);
    press(4'd5); press(4'd11); press(4'd2); press(4'd3);
    n_acc = 0;
    press(4'd13);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (n_acc == 2) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) begin
        total++;
        bad++;
        $display("FAIL t6_two_bytes_timeout: got %0d bytes required 2", n_acc);
      end
    end
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_disp", {16'd0, disp_val}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_sb_empty", sb.size(), 32'd0);
    push(8'h33); push(8'h0D); push(8'h0A);
    press(4'd3); press(4'd13);
    wait_done("t6");

    repeat (10) @(posedge clk);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Sequences the calculator path.
- Consumes decoded key codes: 0-9 digit, 10 add, 11 subtract, 12 clear, 13 equal.
- Builds two multi-digit decimal operands, computes sum or difference, and converts the result to decimal.
- Streams the result as ASCII bytes to the UART transmitter over a valid/ready handshake.
- Sits between the keypad decode stage and the UART TX block.

Parameters:
- DIGITS, 4, maximum decimal digits per operand; further digits are dropped.
- W, 16, operand/result magnitude width; must satisfy 2^W > 2*10^DIGITS.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  key code as listed above; 14 and 15 are ignored.
- tx_data  output  8  ASCII byte to transmitter.
- tx_valid  output  1  tx_data is valid; held until accepted.
- tx_ready  input  1  transmitter accepts the byte on a cycle where tx_valid=1.
- busy  output  1  high while computing or sending; keys are dropped while high.
- disp_val  output  W  operand currently being entered (A, or B after an operator).
- ovf  output  1  sticky; set when a digit is dropped for exceeding DIGITS.

Behaviour:
- Reset (async, any state): state=S_A, A=B=0, digit counters=0, op=add, tx_data=0, tx_valid=0, busy=0, disp_val=0, ovf=0. Takes effect immediately, including mid-send; a partial byte stream is abandoned.
- A key is accepted only when key_valid=1 and busy=0; all other cycles ignore key_code.
- Digit d: if count<DIGITS then operand = operand*10 + d and count++; else operand is unchanged and ovf<=1.
- S_A (entering A):
  - digit accumulates A.
  - 10/11 sets op=add/sub, B=0, count_b=0, goes to S_B.
  - 13 computes with result A (no operation; B treated as 0, op add).
  - 12 clears.
- S_B (entering B):
  - digit accumulates B.
  - 10/11 replaces op only if count_b=0; otherwise ignored.
  - 13 computes A op B (B=0 if no digits entered).
  - 12 clears.
- Clear (12) in S_A/S_B: A=B=0, counts=0, op=add, ovf=0, state S_A.
- Compute: busy rises the cycle after the equal key is accepted.
- S_CALC (1 cycle):
  - add: neg=0, mag=A+B.
  - sub: if A>=B then neg=0, mag=A-B; else neg=1, mag=B-A.
- S_CONV: double-dabble of mag, exactly one bit per cycle, W cycles, yielding DIGITS+1 BCD digits.
- S_SEND byte order:
  - 0x2D ('-') only if neg=1.
  - Decimal digits MS-first as 0x30+digit, leading zeros suppressed; mag=0 sends a single 0x30.
  - 0x0D, then 0x0A.
- Handshake:
  - tx_valid=1 with tx_data stable until a clk edge where tx_ready=1.
  - The next byte is presented on the following cycle, with tx_valid staying high.
  - No byte is skipped or repeated.
- End of send: on the edge accepting 0x0A, tx_valid<=0, busy<=0, A=B=0, counts=0, op=add, ovf=0, state S_A.
- disp_val: equals A in S_A, B in S_B, and holds its last value during busy.
- tx_ready asserted while tx_valid=0 has no effect.
- key_valid coinciding with the final-byte acceptance edge is dropped, since busy is still 1.

Test Plan:
- Keys 1,2,10,7,13 with tx_ready=1 -> bytes 0x31,0x39,0x0D,0x0A ("19"); busy high from the cycle after 13 until after 0x0A; ends in S_A with disp_val=0.
- Keys 5,11,2,3,13 -> "-18\r\n" (0x2D,0x31,0x38,0x0D,0x0A).
- Keys 1,2,3,4,5,6 (DIGITS=4) -> disp_val=1234, ovf=1; then 12 -> disp_val=0, ovf=0.
- Keys 0,13 -> 0x30,0x0D,0x0A. Keys 9,9,9,9,10,9,9,9,9,13 -> "19998\r\n".
- tx_ready held low 5 cycles per byte -> tx_data and tx_valid stable across each stall; key strobes (e.g. 4) injected during busy -> no change to output or to the next operand.
- rst asserted after the second byte of "-18" -> tx_valid=0 and busy=0 immediately; afterwards keys 3,13 -> "3\r\n".
